// File: rtl/polyphase_cic_decim.sv
// Polyphase sinc^1/sinc^2 lane combiner followed by an integrate-and-dump decimator.
// Optional: define POLYCIC_ROUND_EN for round-half-up with saturation on the output reduction.

module polycic_lane #(
   parameter int BW    = 6,
   parameter int LOG2L = 2,
   parameter int IDX   = 0
) (
   input  logic signed [BW-1:0]          cur,
   input  logic signed [BW-1:0]          prev,
   input  logic                          ord2,
   output logic signed [BW+2*LOG2L-1:0]  term
);
   localparam int SW = BW + 2*LOG2L;
   localparam int L  = 1 << LOG2L;
   localparam logic signed [SW-1:0] WC = SW'(L - IDX);
   localparam logic signed [SW-1:0] WP = SW'(IDX);

   logic signed [SW-1:0] cx, px;

   assign cx = SW'(cur);
   assign px = SW'(prev);
   // sinc^2 taps: current lane weighted L-i, previous-frame lane weighted i
   assign term = ord2 ? (cx * WC + px * WP) : (cx <<< LOG2L);
endmodule

module polyphase_cic_decim #(
   parameter int BW    = 6,
   parameter int LOG2L = 2,
   parameter int LOG2R = 1,
   parameter int OUTW  = 10
) (
   input  logic                           CLK,
   input  logic                           RES,
   input  logic [(1<<LOG2L)*BW-1:0]       IN_BUS,
   input  logic                           IN_VLD,
   input  logic                           ORD2,
   input  logic                           CLR,
   output logic signed [OUTW-1:0]         OUT,
   output logic                           OUT_VLD
);
   localparam int L  = 1 << LOG2L;
   localparam int R  = 1 << LOG2R;
   localparam int SW = BW + 2*LOG2L;
   localparam int FW = SW + LOG2R;
   localparam int SH = FW - OUTW;
   localparam int CW = (LOG2R > 0) ? LOG2R : 1;

   logic [L-1:0][BW-1:0] cur, prev;
   logic [L-1:0][SW-1:0] term;
   logic signed [SW-1:0] s_sum, s_reg;
   logic                 s_vld;
   logic signed [FW-1:0] acc, d;
   logic [CW-1:0]        cnt;
   logic                 last;
   logic signed [OUTW-1:0] red;

   assign cur = IN_BUS;

   for (genvar i = 0; i < L; i++) begin : g_lane
      polycic_lane #(.BW(BW), .LOG2L(LOG2L), .IDX(i)) u_lane (
         .cur  (cur[i]),
         .prev (prev[i]),
         .ord2 (ORD2),
         .term (term[i])
      );
   end

   always_comb begin
      s_sum = '0;
      for (int i = 0; i < L; i++) s_sum = s_sum + term[i];
   end

   always_ff @(posedge CLK) begin
      if (!RES) begin
         prev  <= '0;
         s_reg <= '0;
         s_vld <= 1'b0;
      end else if (CLR) begin
         prev  <= '0;
         s_vld <= 1'b0;
      end else if (IN_VLD) begin
         prev  <= cur;
         s_reg <= s_sum;
         s_vld <= 1'b1;
      end else begin
         s_vld <= 1'b0;
      end
   end

   assign d    = acc + FW'(s_reg);
   assign last = (LOG2R == 0) || (cnt == CW'(R - 1));

`ifdef POLYCIC_ROUND_EN
   if (SH == 0) begin : g_pass
      assign red = d;
   end else begin : g_rnd
      localparam logic signed [FW:0] HALF = {{FW{1'b0}}, 1'b1} << (SH - 1);
      logic signed [FW:0] rnd, q;
      logic               ovf;
      assign rnd = (FW+1)'(d) + HALF;
      assign q   = rnd >>> SH;
      // any disagreement among the bits above the output sign bit means overflow
      assign ovf = !((&q[FW:OUTW-1]) || !(|q[FW:OUTW-1]));
      assign red = ovf ? {q[FW], {(OUTW-1){~q[FW]}}} : q[OUTW-1:0];
   end
`else
   assign red = OUTW'(d >>> SH);
`endif

   always_ff @(posedge CLK) begin
      if (!RES) begin
         acc     <= '0;
         cnt     <= '0;
         OUT     <= '0;
         OUT_VLD <= 1'b0;
      end else if (CLR) begin
         acc     <= '0;
         cnt     <= '0;
         OUT_VLD <= 1'b0;
      end else begin
         OUT_VLD <= 1'b0;
         if (s_vld) begin
            if (last) begin
               OUT     <= red;
               OUT_VLD <= 1'b1;
               acc     <= '0;
               cnt     <= '0;
            end else begin
               acc <= d;
               cnt <= cnt + 1'b1;
            end
         end
      end
   end
endmodule
